tx_flit_arbiter: RTL
====================

// Module: tx_flit_arbiter
// PURPOSE
//  Registered 4-way arbiter between the NoC's outgoing flit queues and interdevice_controller TX port.
//  Sources: ack_flit_queue, waiting-ack retransmit output, forwarded_flit_queue, cpu_to_noc_buffer.
//  Selects one flit per cycle by fixed priority plus per-channel starvation aging.
//  Drives a one-entry output register; full throughput (1 flit/cycle) under continuous downstream ready.
// PARAMETERS
//  STARVE_LIMIT  8  consecutive lost arbitration cycles before a channel is promoted to top priority (>=1)
//  CNT_W         $clog2(STARVE_LIMIT+1)  starvation counter width (derived, not overridden)
// PORTS
//  nocclk          in   1           NoC clock; all logic on rising edge
//  rst             in   1           synchronous reset, active-high
//  in_flit[c]      in   4*flit_t    candidate flits; c = 0 ack, 1 retransmit, 2 forwarded, 3 cpu_to_noc
//  in_valid[c]     in   4           candidate valid per channel
//  in_ready[c]     out  4           channel c is popped this cycle (one-hot or zero)
//  flit_out        out  flit_t      registered flit to interdevice_controller
//  flit_out_valid  out  1           flit_out holds a flit
//  flit_out_ready  in   1           interdevice_controller accepts flit_out
//  flit_out_src    out  2           channel index the held flit came from (debug/trace)
//  starved         out  4           channel c's counter is at STARVE_LIMIT (debug)
// BEHAVIOUR
//  Reset (rst=1 at edge): flit_out_valid=0, flit_out=0, flit_out_src=0, all counters=0; in_ready=0 while rst.
//  load_en = !flit_out_valid || flit_out_ready (combinational).
//  Arbitration (combinational, only among in_valid):
//   - if any valid channel has starved[c]=1: grant the lowest-index such channel
//   - else grant the lowest-index valid channel (ack > retransmit > forwarded > cpu)
//  in_ready[c] = load_en && grant[c]; handshake on in_valid[c] && in_ready[c].
//  in_ready never depends on in_valid of the same channel only through grant; no combinational path from flit_out_ready to in_flit.
//  On handshake: flit_out<=in_flit[g], flit_out_src<=g, flit_out_valid<=1 (latency: 1 cycle input->output).
//  If load_en and no channel valid: flit_out_valid<=0 (flit_out, flit_out_src hold).
//  If !load_en: output register holds; no grants; counters hold.
//  Starvation counter cnt[c], channels 0..3:
//   - reset to 0 when c is granted, or when in_valid[c]=0
//   - +1 when in_valid[c]=1, load_en=1, and another channel granted; saturate at STARVE_LIMIT
//   - starved[c] = (cnt[c]==STARVE_LIMIT)
//  Simultaneous pop+push: flit_out_valid && flit_out_ready && new grant -> output replaced same edge, stays valid.
//  Source retracting in_valid without handshake is a source bug; arbiter just re-arbitrates next cycle.
//  Reset mid-operation: held flit dropped; upstream queues keep their contents (no pop happened).
//  No packet lock: flits of different packets may interleave on the output; routing is per-flit.
// STRUCTURE
//  types package: flit_t (existing); add tx_src_e {TX_SRC_ACK, TX_SRC_RETX, TX_SRC_FWD, TX_SRC_CPU}
//   and TX_STARVE_LIMIT default constant.
//  Sub-module: tx_starve_counter (one instance per channel: valid/granted/load_en -> starved).
//  Top: grant comb logic + output register; replaces tx_buffer_selector_comb in noc.
// TESTING
//  1 Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, flit_out_valid=0, starved=0.
//  2 Priority: all four valid at once, flit_out_ready=1 -> outputs src 0,1,2,3 on consecutive cycles
//    (valids drop after handshake).
//  3 Starvation: ack valid continuously, cpu valid, STARVE_LIMIT=8
//    -> 8 ack grants, then cpu granted on 9th arbitration, cnt[3] back to 0.
//  4 Backpressure: flit_out_ready=0 for 5 cycles with flit held -> flit_out stable, in_ready=0,
//    counters frozen; ready=1 -> next grant same edge.
//  5 Throughput: cpu valid every cycle, ready=1 -> 1 flit/cycle, flit_out equals in_flit[3] delayed exactly 1 cycle.
//  6 Mid-op reset: reset asserted while flit_out_valid=1 and ready=0 -> valid=0 next edge, no in_ready pulse.

Source files
------------

// File: rtl/tx_flit_arbiter_pkg.sv
// Types and helpers shared by the NoC TX flit arbiter and its sub-modules.
package tx_flit_arbiter_pkg;

   localparam int unsigned TX_NUM_CH       = 4;
   localparam int unsigned TX_STARVE_LIMIT = 8;

   // NoC flit as seen on the interdevice TX path (32 bits total).
   typedef struct packed {
      logic [1:0]  flit_type;
      logic [3:0]  dest;
      logic [25:0] payload;
   } flit_t;

   // Channel index of each arbiter source; lower value means higher fixed priority.
   typedef enum logic [1:0] {
      TX_SRC_ACK  = 2'd0,
      TX_SRC_RETX = 2'd1,
      TX_SRC_FWD  = 2'd2,
      TX_SRC_CPU  = 2'd3
   } tx_src_e;

   // Keep only the lowest-index set bit of a request vector.
   function automatic logic [3:0] tx_lowest_onehot(input logic [3:0] req);
      logic [3:0] oh;
      casez (req)
         4'b???1: oh = 4'b0001;
         4'b??10: oh = 4'b0010;
         4'b?100: oh = 4'b0100;
         4'b1000: oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   // Encode a one-hot grant into a source index (zero vector maps to ACK).
   function automatic tx_src_e tx_onehot_to_src(input logic [3:0] oh);
      tx_src_e src;
      case (oh)
         4'b0001: src = TX_SRC_ACK;
         4'b0010: src = TX_SRC_RETX;
         4'b0100: src = TX_SRC_FWD;
         4'b1000: src = TX_SRC_CPU;
         default: src = TX_SRC_ACK;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/tx_flit_arbiter_starve.sv
// Per-channel starvation counter: counts consecutive lost arbitrations of a
// waiting channel and flags it once the count reaches STARVE_LIMIT.
module tx_starve_counter
   import tx_flit_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = TX_STARVE_LIMIT,
   parameter int unsigned CNT_W        = $clog2(TX_STARVE_LIMIT + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid_i,
   input  logic granted_i,
   input  logic any_grant_i,
   input  logic load_en_i,
   output logic starved_o
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             starved_q;

   // Next count: frozen under backpressure, cleared when idle or served, else ages to the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (!load_en_i) begin
         cnt_d = cnt_q;
      end else if (!valid_i || granted_i) begin
         cnt_d = ZERO_C;
      end else if (any_grant_i && (cnt_q != LIMIT_C)) begin
         cnt_d = cnt_q + ONE_C;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter and registered starved flag (flag always mirrors cnt_q == limit).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= ZERO_C;
         starved_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         starved_q <= (cnt_d == LIMIT_C);
      end
   end

   assign starved_o = starved_q;

endmodule

// File: rtl/tx_flit_arbiter.sv
// Registered 4-way arbiter feeding the interdevice TX port from the ack,
// retransmit, forwarded and cpu_to_noc flit sources. Fixed priority by channel
// index, overridden by starvation aging; one-entry output register sustains
// one flit per cycle while the downstream keeps ready high.
module tx_flit_arbiter
   import tx_flit_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = TX_STARVE_LIMIT
) (
   input  logic        nocclk,
   input  logic        rst,
   input  flit_t [3:0] in_flit,
   input  logic [3:0]  in_valid,
   output logic [3:0]  in_ready,
   output flit_t       flit_out,
   output logic        flit_out_valid,
   input  logic        flit_out_ready,
   output logic [1:0]  flit_out_src,
   output logic [3:0]  starved
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic       load_en_s;
   logic [3:0] starved_s;
   logic [3:0] starve_req_s;
   logic [3:0] grant_s;
   logic [3:0] ready_s;
   logic       any_grant_s;
   tx_src_e    grant_src_s;
   logic [1:0] grant_idx_s;

   flit_t      flit_q;
   flit_t      flit_d;
   logic [1:0] src_q;
   logic [1:0] src_d;
   logic       valid_q;
   logic       valid_d;

   // The output register can take a new flit when empty or being drained this cycle.
   assign load_en_s = !valid_q || flit_out_ready;

   // Grant: starved valid channels win first (lowest index), otherwise plain fixed priority.
   always_comb begin
      starve_req_s = in_valid & starved_s;
      if (|starve_req_s) begin
         grant_s = tx_lowest_onehot(starve_req_s);
      end else begin
         grant_s = tx_lowest_onehot(in_valid);
      end
   end

   // Pop strobes: only when the output register accepts and never while in reset.
   always_comb begin
      if (load_en_s && !rst) begin
         ready_s = grant_s;
      end else begin
         ready_s = 4'b0000;
      end
   end

   assign in_ready    = ready_s;
   assign any_grant_s = |ready_s;
   assign grant_src_s = tx_onehot_to_src(grant_s);
   assign grant_idx_s = grant_src_s;

   // Output register next-state: load the granted flit, or go empty when nothing is offered.
   always_comb begin
      flit_d  = flit_q;
      src_d   = src_q;
      valid_d = valid_q;
      if (load_en_s) begin
         if (any_grant_s) begin
            flit_d  = in_flit[grant_idx_s];
            src_d   = grant_idx_s;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // Output register; reset drops any held flit.
   always_ff @(posedge nocclk) begin
      if (rst) begin
         flit_q  <= {$bits(flit_t){1'b0}};
         src_q   <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         flit_q  <= flit_d;
         src_q   <= src_d;
         valid_q <= valid_d;
      end
   end

   assign flit_out       = flit_q;
   assign flit_out_src   = src_q;
   assign flit_out_valid = valid_q;
   assign starved        = starved_s;

   for (genvar c = 0; c < 4; c++) begin : g_starve
      tx_starve_counter #(
         .STARVE_LIMIT (STARVE_LIMIT),
         .CNT_W        (CNT_W)
      ) u_starve (
         .clk_i       (nocclk),
         .rst_i       (rst),
         .valid_i     (in_valid[c]),
         .granted_i   (ready_s[c]),
         .any_grant_i (any_grant_s),
         .load_en_i   (load_en_s),
         .starved_o   (starved_s[c])
      );
   end

endmodule
